// File: rtl/dfp_arbiter_pkg.sv
// cache_types: shared types for the DRAM-facing port arbiter.
// Rev 1.0
`default_nettype none

package cache_types;

    localparam int DFP_ADDR_BITS = 32;
    localparam int DFP_LINE_BITS = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        COOL   = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [DFP_ADDR_BITS-1:0] addr;
        logic                     read;
        logic                     write;
        logic [DFP_LINE_BITS-1:0] wdata;
    } dfp_req_t;

endpackage

`default_nettype wire

// File: rtl/dfp_arbiter_rr_picker.sv
// rr_picker: round-robin selector, first pending index after ptr (with wrap).
// Rev 1.0
`default_nettype none

module rr_picker #(
    parameter  int NUM_REQ  = 4,
    localparam int IDX_BITS = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  pending_i,
    input  logic [IDX_BITS-1:0] ptr_i,
    output logic [NUM_REQ-1:0]  gnt_o,
    output logic [IDX_BITS-1:0] gnt_idx_o,
    output logic                any_o
);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;

    // Doubling the vector turns the wrap-around scan into a plain shift.
    assign w_dbl = {pending_i, pending_i};
    assign w_rot = NUM_REQ'(w_dbl >> (int'(ptr_i) + 1));
    assign any_o = |pending_i;

    always_comb begin
        int off;
        int sum;
        off = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                off = k;
            end
        end
        sum = int'(ptr_i) + 1 + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        gnt_idx_o = IDX_BITS'(sum);
        gnt_o     = '0;
        if (any_o) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dfp_arbiter.sv
// dfp_arbiter: round-robin sharing of one DRAM-facing port, one transaction in flight.
// Rev 1.0
`default_nettype none

module dfp_arbiter
    import cache_types::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int LINE_BITS = DFP_LINE_BITS,
    parameter  int ADDR_BITS = DFP_ADDR_BITS,
    localparam int IDX_BITS  = $clog2(NUM_REQ)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0][ADDR_BITS-1:0]  req_addr_i,
    input  logic [NUM_REQ-1:0]                 req_read_i,
    input  logic [NUM_REQ-1:0]                 req_write_i,
    input  logic [NUM_REQ-1:0][LINE_BITS-1:0]  req_wdata_i,
    output logic [LINE_BITS-1:0]               req_rdata_o,
    output logic [NUM_REQ-1:0]                 req_resp_o,
    output logic [ADDR_BITS-1:0]               mem_addr_o,
    output logic                               mem_read_o,
    output logic                               mem_write_o,
    output logic [LINE_BITS-1:0]               mem_wdata_o,
    input  logic [LINE_BITS-1:0]               mem_rdata_i,
    input  logic                               mem_resp_i,
    output logic [IDX_BITS-1:0]                gnt_idx_o,
    output logic                               busy_o
);

    arb_state_t          state_q;
    logic [IDX_BITS-1:0] ptr_q;
    logic [IDX_BITS-1:0] gnt_q;
    dfp_req_t            req_q;

    logic [NUM_REQ-1:0]  w_pending;
    logic [NUM_REQ-1:0]  w_gnt;
    logic [IDX_BITS-1:0] w_win;
    logic                w_any;
    logic                w_wr;
    logic                w_rd;

    assign w_pending = req_read_i | req_write_i;

    rr_picker #(
        .NUM_REQ(NUM_REQ)
    ) u_picker (
        .pending_i(w_pending),
        .ptr_i    (ptr_q),
        .gnt_o    (w_gnt),
        .gnt_idx_o(w_win),
        .any_o    (w_any)
    );

    // Write takes precedence when a slice raises both ops.
    assign w_wr = |(w_gnt & req_write_i);
    assign w_rd = |(w_gnt & req_read_i) & ~w_wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= IDX_BITS'(NUM_REQ - 1);
            gnt_q   <= '0;
            req_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_any) begin
                        req_q.addr  <= req_addr_i[w_win];
                        req_q.wdata <= req_wdata_i[w_win];
                        req_q.read  <= w_rd;
                        req_q.write <= w_wr;
                        gnt_q       <= w_win;
                        state_q     <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (mem_resp_i) begin
                        req_q.read  <= 1'b0;
                        req_q.write <= 1'b0;
                        ptr_q       <= gnt_q;
                        state_q     <= COOL;
                    end
                end
                COOL: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_addr_o  = req_q.addr;
    assign mem_wdata_o = req_q.wdata;
    assign mem_read_o  = req_q.read;
    assign mem_write_o = req_q.write;
    assign req_rdata_o = mem_rdata_i;
    assign gnt_idx_o   = gnt_q;
    assign busy_o      = (state_q == ACTIVE);

    always_comb begin
        req_resp_o = '0;
        if ((state_q == ACTIVE) && mem_resp_i) begin
            req_resp_o[gnt_q] = 1'b1;
        end
    end

    a_rd_wr_both : assert property (@(posedge clk) disable iff (rst)
        !(|(req_read_i & req_write_i)))
        else $warning("dfp_arbiter: read and write raised together, write takes priority");

    a_stale_resp : assert property (@(posedge clk) disable iff (rst)
        mem_resp_i |-> (state_q == ACTIVE))
        else $warning("dfp_arbiter: mem_resp outside ACTIVE ignored");

endmodule

`default_nettype wire

// File: tb/tb_dfp_arbiter.sv
// tb_dfp_arbiter: table vectors plus scoreboarded multi-cycle sequences for dfp_arbiter.
// Rev 1.0
`default_nettype none

module tb_dfp_arbiter;
    import cache_types::*;

    localparam int NR = 4;
    localparam int LB = 256;
    localparam int AB = 32;
    localparam int IB = 2;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NR-1:0][AB-1:0]   req_addr_i;
    logic [NR-1:0]           req_read_i;
    logic [NR-1:0]           req_write_i;
    logic [NR-1:0][LB-1:0]   req_wdata_i;
    logic [LB-1:0]           req_rdata_o;
    logic [NR-1:0]           req_resp_o;
    logic [AB-1:0]           mem_addr_o;
    logic                    mem_read_o;
    logic                    mem_write_o;
    logic [LB-1:0]           mem_wdata_o;
    logic [LB-1:0]           mem_rdata_i;
    logic                    mem_resp_i;
    logic [IB-1:0]           gnt_idx_o;
    logic                    busy_o;

    always #5 clk = ~clk;

    dfp_arbiter #(
        .NUM_REQ  (NR),
        .LINE_BITS(LB),
        .ADDR_BITS(AB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_addr_i (req_addr_i),
        .req_read_i (req_read_i),
        .req_write_i(req_write_i),
        .req_wdata_i(req_wdata_i),
        .req_rdata_o(req_rdata_o),
        .req_resp_o (req_resp_o),
        .mem_addr_o (mem_addr_o),
        .mem_read_o (mem_read_o),
        .mem_write_o(mem_write_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .mem_resp_i (mem_resp_i),
        .gnt_idx_o  (gnt_idx_o),
        .busy_o     (busy_o)
    );

    typedef struct {
        int            slice;
        bit            wr;
        logic [AB-1:0] addr;
        logic [LB-1:0] wdata;
        logic [LB-1:0] rdata;
        int            lat;
    } vec_t;

    vec_t exp_q[$];
    vec_t vecs[5];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [LB-1:0] rep32(input logic [31:0] w);
        return {8{w}};
    endfunction

    task automatic chk(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req_addr_i[v.slice]  = v.addr;
        req_wdata_i[v.slice] = v.wdata;
        if (v.wr) req_write_i[v.slice] = 1'b1;
        else      req_read_i[v.slice]  = 1'b1;
        exp_q.push_back(v);
    endtask

    // Memory model: waits for an issued op, checks it against the scoreboard head,
    // answers after lat cycles and checks the routed response.
    task automatic serve(input bit hold, input bit chk_lat, output vec_t got);
        vec_t e;
        int   cyc  = 0;
        bit   seen = 1'b0;
        got = '{-1, 1'b0, '0, '0, '0, 0};
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            cyc++;
            if (mem_read_o || mem_write_o) seen = 1'b1;
        end
        if (!seen) begin
            chk("grant_timeout", 256'(0), 256'(1));
            return;
        end
        if (exp_q.size() == 0) begin
            chk("unexpected_txn", 256'(0), 256'(1));
            return;
        end
        e   = exp_q.pop_front();
        got = e;
        if (chk_lat) chk("arb_latency", 256'(cyc), 256'(1));
        chk("gnt_idx", 256'(gnt_idx_o), 256'(e.slice));
        chk("busy_active", 256'(busy_o), 256'(1));
        for (int c = 0; c < e.lat; c++) begin
            chk("mem_addr", 256'(mem_addr_o), 256'(e.addr));
            chk("mem_read", 256'(mem_read_o), 256'(!e.wr));
            chk("mem_write", 256'(mem_write_o), 256'(e.wr));
            if (e.wr) chk("mem_wdata", mem_wdata_o, e.wdata);
            if (c == e.lat - 1) begin
                mem_resp_i  = 1'b1;
                mem_rdata_i = e.rdata;
                #1;
                chk("req_resp", 256'(req_resp_o), 256'(1) << e.slice);
                chk("req_rdata", req_rdata_o, e.rdata);
            end else begin
                chk("req_resp_early", 256'(req_resp_o), 256'(0));
                @(negedge clk);
            end
        end
        @(negedge clk);
        mem_resp_i  = 1'b0;
        mem_rdata_i = {8{$urandom()}};
        chk("cool_busy", 256'(busy_o), 256'(0));
        chk("cool_mem_read", 256'(mem_read_o), 256'(0));
        if (hold) begin
            @(negedge clk);
            chk("hold_no_reissue_rd", 256'(mem_read_o), 256'(0));
            chk("hold_no_reissue_wr", 256'(mem_write_o), 256'(0));
            chk("hold_busy", 256'(busy_o), 256'(0));
        end
        req_read_i[e.slice]  = 1'b0;
        req_write_i[e.slice] = 1'b0;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        req_read_i  = '0;
        req_write_i = '0;
        mem_resp_i  = 1'b0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t got;
        vec_t v;
        req_addr_i  = '0;
        req_read_i  = '0;
        req_write_i = '0;
        req_wdata_i = '0;
        mem_rdata_i = '0;
        mem_resp_i  = 1'b0;
        rst         = 1'b1;

        @(negedge clk);
        chk("rst_mem_read", 256'(mem_read_o), 256'(0));
        chk("rst_mem_write", 256'(mem_write_o), 256'(0));
        chk("rst_mem_addr", 256'(mem_addr_o), 256'(0));
        chk("rst_mem_wdata", mem_wdata_o, '0);
        chk("rst_req_resp", 256'(req_resp_o), 256'(0));
        chk("rst_busy", 256'(busy_o), 256'(0));
        chk("rst_gnt_idx", 256'(gnt_idx_o), 256'(0));
        chk("rst_state", 256'(dut.state_q), 256'(IDLE));
        rst = 1'b0;
        @(negedge clk);

        vecs[0] = '{2, 1'b0, 32'h0000_1000, '0, rep32(32'hA5A5_A5A5), 5};
        vecs[1] = '{1, 1'b1, 32'h0000_2040, rep32(32'hDEAD_BEEF), rep32(32'h1111_2222), 3};
        vecs[2] = '{0, 1'b0, 32'h0000_3000, '0, rep32(32'h0123_4567), 1};
        vecs[3] = '{3, 1'b1, 32'hFFFF_FFC0, rep32(32'hC001_D00D), '0, 2};
        vecs[4] = '{3, 1'b0, 32'h0000_0040, '0, rep32(32'h5A5A_0F0F), 4};
        for (int i = 0; i < 5; i++) begin
            drive(vecs[i]);
            serve(1'b0, 1'b1, got);
            @(negedge clk);
        end

        // Contention: 0, 1, 3 requesting from reset release, each re-requests once.
        rst = 1'b1;
        req_read_i  = '0;
        req_write_i = '0;
        exp_q.delete();
        drive('{0, 1'b0, 32'h0000_0100, '0, rep32(32'h0000_00A0), 2});
        drive('{1, 1'b0, 32'h0000_0200, '0, rep32(32'h0000_00A1), 2});
        drive('{3, 1'b1, 32'h0000_0400, rep32(32'h0000_00B3), '0, 2});
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            serve(1'b0, 1'b0, got);
            if (k < 3 && got.slice >= 0) begin
                @(negedge clk);
                v      = got;
                v.addr = got.addr + 32'h40;
                drive(v);
            end
        end
        chk("contention_drained", 256'(exp_q.size()), 256'(0));

        // Cooldown: slice 0 holds its request through the COOL cycle.
        do_reset();
        drive('{0, 1'b0, 32'h0000_5000, '0, rep32(32'h7777_0000), 2});
        drive('{1, 1'b0, 32'h0000_6000, '0, rep32(32'h7777_0001), 2});
        serve(1'b1, 1'b1, got);
        serve(1'b0, 1'b0, got);
        chk("cool_next_slice", 256'(got.slice), 256'(1));

        // Reset two cycles into ACTIVE, then a stale response.
        do_reset();
        drive('{2, 1'b0, 32'h0000_3300, '0, '0, 9});
        @(negedge clk);
        chk("pre_rst_mem_read", 256'(mem_read_o), 256'(1));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_mem_read", 256'(mem_read_o), 256'(0));
        chk("midrst_busy", 256'(busy_o), 256'(0));
        chk("midrst_mem_addr", 256'(mem_addr_o), 256'(0));
        void'(exp_q.pop_front());
        req_read_i = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_resp_i  = 1'b1;
        mem_rdata_i = rep32(32'hBAD0_BAD0);
        #1;
        chk("stale_req_resp", 256'(req_resp_o), 256'(0));
        @(negedge clk);
        mem_resp_i = 1'b0;
        chk("stale_state", 256'(dut.state_q), 256'(IDLE));
        chk("stale_mem_read", 256'(mem_read_o), 256'(0));
        chk("stale_busy", 256'(busy_o), 256'(0));

        // Wrap-around: after slice 3, slice 0 outranks slice 3.
        do_reset();
        drive('{3, 1'b0, 32'h0000_7000, '0, rep32(32'h3333_3333), 2});
        serve(1'b0, 1'b1, got);
        @(negedge clk);
        drive('{0, 1'b0, 32'h0000_8000, '0, rep32(32'h0000_0000), 2});
        drive('{3, 1'b0, 32'h0000_9000, '0, rep32(32'h3333_0003), 2});
        serve(1'b0, 1'b1, got);
        chk("wrap_first", 256'(got.slice), 256'(0));
        serve(1'b0, 1'b0, got);
        chk("wrap_second", 256'(got.slice), 256'(3));
        chk("wrap_drained", 256'(exp_q.size()), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dfp_arbiter.md
Name: dfp_arbiter

Overview:
- Shares the single DRAM-facing port (dfp_*, 256-bit line, read/write/resp handshake) between NUM_REQ cache slices: L2 instances, plus the optional uncached path.
- Sits between the per-slice dfp ports and the memory model/controller.
- Round-robin fair, one outstanding transaction at a time.
- Requester-side protocol is identical to the memory-side protocol, so a slice cannot tell it is behind an arbiter, apart from added latency.

Parameters:
- NUM_REQ, 4, number of requesting slices (>=2).
- LINE_BITS, 256, cacheline data width.
- ADDR_BITS, 32, byte address width.
- IDX_BITS, $clog2(NUM_REQ), localparam, winner index width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_addr  in  NUM_REQ x ADDR_BITS  per-slice line address (packed array)
- req_read  in  NUM_REQ  per-slice read request
- req_write  in  NUM_REQ  per-slice write request
- req_wdata  in  NUM_REQ x LINE_BITS  per-slice writeback data
- req_rdata  out  LINE_BITS  shared return data, valid only with a req_resp bit
- req_resp  out  NUM_REQ  one-hot completion
- mem_addr  out  ADDR_BITS  to memory
- mem_read  out  1  to memory
- mem_write  out  1  to memory
- mem_wdata  out  LINE_BITS  to memory
- mem_rdata  in  LINE_BITS  from memory
- mem_resp  in  1  from memory
- gnt_idx  out  IDX_BITS  current or last winner, for debug/perf
- busy  out  1  transaction outstanding

Behaviour:
- Reset values (asynchronous, immediate):
  - state=IDLE, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - req_resp=0, busy=0, gnt_idx=0.
  - Priority pointer = NUM_REQ-1, so requester 0 is highest priority first.
- FSM: IDLE -> ACTIVE -> COOL -> IDLE.
- IDLE:
  - pending[i] = req_read[i] | req_write[i].
  - Winner = first pending index scanning ptr+1, ptr+2, ... with wrap mod NUM_REQ.
  - If any request is pending, register addr, wdata, op and winner at the edge, then go to ACTIVE.
  - mem_read/mem_write assert the cycle after the request is first visible (1-cycle arbitration latency).
- ACTIVE:
  - mem_* outputs come from registers and stay stable until mem_resp.
  - On the mem_resp cycle, combinationally: req_resp[winner]=1 and req_rdata=mem_rdata (0 added return latency).
  - At that edge: clear mem_read/mem_write, set ptr=winner, go to COOL.
- COOL:
  - Lasts one cycle; all requests are ignored so the served slice can drop its request.
  - Requesters must deassert the cycle after their resp.
  - Then go to IDLE.
- Requester changes while ACTIVE are ignored. A requester must hold addr, wdata and op until its resp.
- If a requester asserts read and write together, write wins and a simulation assertion fires.
- mem_resp in IDLE or COOL is ignored (stale response), and a simulation assertion fires.
- req_rdata is driven to mem_rdata at all times. Consumers qualify it with req_resp.
- busy=1 in ACTIVE only.
- Reset asserted mid-ACTIVE: outputs clear immediately and any in-flight memory response is dropped.
- Fairness: a continuously requesting slice waits at most NUM_REQ-1 transactions.

Decomposition:
- Package cache_types gains the dfp_req_t struct {addr, read, write, wdata} and the arb_state_t enum {IDLE, ACTIVE, COOL}.
- Sub-module rr_picker:
  - Combinational, parameter NUM_REQ.
  - Inputs: pending vector, ptr.
  - Outputs: one-hot gnt, gnt_idx, any.
  - Implemented as a double-width rotate and priority-encode.

Test Plan:
- Single read:
  - Stimulus: slice 2 reads 0x0000_1000; memory answers after 5 cycles with data 0xA5..A5.
  - Required: mem_read rises 1 cycle after the request, mem_addr=0x1000, req_resp=4'b0100 in the same cycle as mem_resp, req_rdata=0xA5..A5.
- Contention:
  - Stimulus: slices 0, 1 and 3 request simultaneously at reset release and re-request after each resp.
  - Required: service order 0, 1, 3, 0, 1, 3; no slice is served twice before the others.
- Write passthrough:
  - Stimulus: slice 1 writes 0x0000_2040 with wdata pattern 0xDEADBEEF repeated.
  - Required: mem_write=1, mem_wdata matches the pattern, req_resp[1] asserted on mem_resp, mem_read=0 throughout.
- Cooldown:
  - Stimulus: slice 0 holds its request one cycle past resp.
  - Required: no second mem_read is issued, and the next transaction grants the other pending slice.
- Reset mid-operation:
  - Stimulus: assert rst 2 cycles into ACTIVE, then memory pulses mem_resp after reset.
  - Required: mem_read=0 immediately, req_resp stays 0, stale-response assertion fires, state=IDLE.
- Wrap-around:
  - Stimulus: after serving slice 3, only slice 3 and slice 0 are pending.
  - Required: slice 0 is granted first.
